// File: rtl/gsens_tilt_filter.sv
`default_nettype none
// gsens_tilt_filter -- per-axis block-averaged accelerometer tilt with saturation and dead zone
// Rev 1.0
module gsens_tilt_filter #(
   parameter int DATA_W   = 10,
   parameter int OUT_W    = 4,
   parameter int AXES     = 2,
   parameter int AVG_LOG2 = 2,
   parameter int DEADZONE = 1,
   parameter int AXIS_W   = (AXES > 1) ? $clog2(AXES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     iDIG,
   input  logic [AXIS_W-1:0]     iAXIS,
   input  logic                  iVALID,
   input  logic                  iHOLD,
   output logic [AXES*OUT_W-1:0] tilt_amount,
   output logic [AXES-1:0]       tilt_direction,
   output logic                  oUPD,
   output logic [AXIS_W-1:0]     oUPD_AXIS,
   output logic                  oDROP
);
   localparam int                ACC_W    = DATA_W + AVG_LOG2;
   localparam int                CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
   localparam logic [DATA_W-2:0] MAG_MAX  = '1;

   logic signed [ACC_W-1:0] acc_q [AXES];
   logic [CNT_W-1:0]        cnt_q [AXES];
   logic [DATA_W-1:0]       s2_avg_q;
   logic [AXIS_W-1:0]       s2_axis_q;
   logic                    s2_vld_q;
   logic [AXES*OUT_W-1:0]   amt_q;
   logic [AXES-1:0]         dir_q;
   logic                    upd_q;
   logic [AXIS_W-1:0]       upd_axis_q;
   logic                    drop_q;

   logic                    in_range;
   logic                    accept;
   logic                    last;
   logic signed [ACC_W-1:0] sel_acc;
   logic [CNT_W-1:0]        sel_cnt;
   logic signed [ACC_W-1:0] sum_d;

   assign in_range = (32'(iAXIS) < AXES);
   assign accept   = iVALID & ~iHOLD & in_range;

   always_comb begin
      sel_acc = '0;
      sel_cnt = '0;
      for (int a = 0; a < AXES; a++) begin
         if (32'(iAXIS) == a) begin
            sel_acc = acc_q[a];
            sel_cnt = cnt_q[a];
         end
      end
   end

   assign sum_d = sel_acc + ACC_W'(signed'(iDIG));
   assign last  = (sel_cnt == CNT_LAST);

   // Stage 1: accumulate; a completed block hands its average (sum >>> AVG_LOG2) to stage 2.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int a = 0; a < AXES; a++) begin
            acc_q[a] <= '0;
            cnt_q[a] <= '0;
         end
         s2_vld_q  <= 1'b0;
         s2_avg_q  <= '0;
         s2_axis_q <= '0;
         drop_q    <= 1'b0;
      end else begin
         s2_vld_q <= accept & last;
         drop_q   <= iVALID & ~iHOLD & ~in_range;
         if (accept & last) begin
            s2_avg_q  <= sum_d[AVG_LOG2 +: DATA_W];
            s2_axis_q <= iAXIS;
         end
         for (int a = 0; a < AXES; a++) begin
            if (accept && (32'(iAXIS) == a)) begin
               if (last) begin
                  acc_q[a] <= '0;
                  cnt_q[a] <= '0;
               end else begin
                  acc_q[a] <= sum_d;
                  cnt_q[a] <= cnt_q[a] + 1'b1;
               end
            end
         end
      end
   end

   logic                neg;
   logic [DATA_W-1:0]   neg_avg;
   logic [DATA_W-2:0]   mag;
   logic [OUT_W-1:0]    amt_raw;
   logic [OUT_W-1:0]    amt_d;
   logic                dir_d;
   logic                unused_mag;

   assign neg     = s2_avg_q[DATA_W-1];
   assign neg_avg = -s2_avg_q;

   // Negating the most-negative average wraps back to itself; clamp it to full scale.
   always_comb begin
      if (!neg) begin
         mag = s2_avg_q[DATA_W-2:0];
      end else if (neg_avg[DATA_W-1]) begin
         mag = MAG_MAX;
      end else begin
         mag = neg_avg[DATA_W-2:0];
      end
   end

   assign amt_raw    = mag[DATA_W-2 -: OUT_W];
   assign unused_mag = ^mag;

   always_comb begin
      amt_d = amt_raw;
      dir_d = neg;
      if (32'(amt_raw) < DEADZONE) begin
         amt_d = '0;
         dir_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         amt_q      <= '0;
         dir_q      <= '0;
         upd_q      <= 1'b0;
         upd_axis_q <= '0;
      end else begin
         upd_q <= s2_vld_q;
         if (s2_vld_q) begin
            upd_axis_q <= s2_axis_q;
            for (int a = 0; a < AXES; a++) begin
               if (32'(s2_axis_q) == a) begin
                  amt_q[a*OUT_W +: OUT_W] <= amt_d;
                  dir_q[a]                <= dir_d;
               end
            end
         end
      end
   end

   assign tilt_amount    = amt_q;
   assign tilt_direction = dir_q;
   assign oUPD           = upd_q;
   assign oUPD_AXIS      = upd_axis_q;
   assign oDROP          = drop_q;

endmodule
`default_nettype wire

// File: doc/gsens_tilt_filter.md
# gsens_tilt_filter

Multi-axis successor to the single-sample G-sensor tilt parser. It accepts a stream of signed two's-complement accelerometer samples tagged with an axis index. For each axis it block-averages 2^AVG_LOG2 samples, converts the average to sign/magnitude with saturation, applies a dead zone, and registers a per-axis tilt amount and direction with an update strobe. It sits between the G-sensor SPI/emulation front end and the game logic that consumes tilt.

## Interface

**Parameters**
- DATA_W, 10: sample width, signed two's complement.
- OUT_W, 4: tilt-amount width. Must satisfy OUT_W ≤ DATA_W-1.
- AXES, 2: number of axes, ≥1.
- AVG_LOG2, 2: log2 of samples per average block. 0 means no averaging.
- DEADZONE, 1: amounts strictly below this value are forced to 0.
- AXIS_W: derived, max(1, $clog2(AXES)).

**Ports**
- clk, in, 1: single clock. All logic is rising-edge.
- reset, in, 1: synchronous, active-high reset.
- iDIG, in, DATA_W: sample value.
- iAXIS, in, AXIS_W: axis index of the sample.
- iVALID, in, 1: sample present this cycle.
- iHOLD, in, 1: freeze. While high, samples are ignored and accumulators are kept.
- tilt_amount, out, AXES*OUT_W: axis a occupies bits [a*OUT_W +: OUT_W].
- tilt_direction, out, AXES: 1 means negative tilt.
- oUPD, out, 1: one-cycle pulse when an axis output is updated.
- oUPD_AXIS, out, AXIS_W: axis updated. Valid only while oUPD is high.
- oDROP, out, 1: one-cycle pulse when a sample is dropped for an out-of-range iAXIS.

## Operation

**Accept condition.** A sample is accepted when iVALID & ~iHOLD & (iAXIS < AXES).
- iVALID & ~iHOLD & (iAXIS ≥ AXES): the sample is dropped, oDROP pulses on the next cycle, and no state changes.

**Per-axis state**
- acc[a]: signed, DATA_W+AVG_LOG2 bits.
- cnt[a]: AVG_LOG2 bits. With AVG_LOG2=0 every sample completes a block.

**Stage 1 (accept cycle)**
- sum = acc[a] + sign_extend(iDIG).
- If cnt[a] == 2^AVG_LOG2-1 (block complete):
  - Register sum and the axis into the stage-2 pipeline register and set its valid bit.
  - Clear acc[a] and cnt[a] to 0.
- Otherwise: acc[a] ← sum, cnt[a] ← cnt[a]+1.
- Samples for different axes may interleave arbitrarily, and one sample per cycle is sustained.

**Stage 2 (next cycle)**
1. avg = sum >>> AVG_LOG2. This is an arithmetic shift, i.e. floor toward −∞.
2. neg = avg[DATA_W-1]. mag = neg ? −avg : avg, saturated to 2^(DATA_W-1)−1, so the most-negative average maps to the maximum magnitude.
3. amt = mag[DATA_W-2 -: OUT_W], the top OUT_W magnitude bits below the sign.
4. If amt < DEADZONE: amt = 0 and dir = 0. Otherwise dir = neg.
5. Register amt and dir into that axis's output slice, assert oUPD, and drive oUPD_AXIS = axis.
   - The update happens even if the values are unchanged.
   - All other axes hold their outputs.

**Reset.** On reset, every acc, cnt, pipeline valid bit, tilt_amount, tilt_direction, oUPD, oUPD_AXIS and oDROP goes to 0.
- A partial block in progress when reset is asserted is discarded.
- A stage-2 result in flight when reset is asserted is discarded, so no oUPD is produced for it.

**Boundary cases**
- A block for axis a completes while stage 2 is still processing a previous block of axis a: allowed. Stage 2 uses the pipelined sum, and the accumulator restarts from 0.
- iHOLD asserted mid-block: accumulation resumes where it left off once iHOLD deasserts.
- The accumulator cannot overflow by construction, since it carries AVG_LOG2 guard bits.

## Timing

- A sample completing a block is sampled at rising edge t. The tilt outputs, oUPD and oUPD_AXIS change at edge t+1 and are visible during the cycle after it. Latency is 2 edges from presentation.
- oUPD is high for exactly one cycle per completed block. Back-to-back completions produce consecutive oUPD pulses.
- oDROP pulses for one cycle, one edge after the dropped sample.
- Outputs are fully registered, with no combinational path from any input to any output.

## Test plan

All scenarios use the defaults: DATA_W=10, OUT_W=4, AXES=2, AVG_LOG2=2, DEADZONE=1.

1. **Reset values.** Assert reset for 2 cycles → all outputs 0. Then four accepted samples of 256 on axis 0 → one oUPD with oUPD_AXIS=0, one edge after the 4th sample is sampled. Axis 0 shows amount 8, dir 0. Axis 1 stays at 0.
2. **Negative and saturation.**
   - Four samples of −256 (10'h300) on axis 1 → axis 1 amount 8, dir 1. Axis 0 is unchanged.
   - Then four samples of −512 (10'h200) on axis 1 → amount 15, dir 1 (saturated).
3. **Rounding and dead zone.**
   - Samples 31 ×4 → amount 0, dir 0.
   - Samples −40 ×4 → amount 1, dir 1.
   - Samples 100, −100, 100, −101 → avg −1 (floor), amount 0, dir 0.
   - Samples 3, 3, 3, 2 → avg 2. Check against a model.
4. **Interleave and gating.**
   - Alternate axis 0 and axis 1 samples on every cycle → oUPD pulses on two consecutive cycles, axis 0 then axis 1.
   - Set iHOLD after 2 samples for 5 cycles, then send 2 more → exactly one update, with averaging over the 4 accepted samples only.
5. **Out-of-range axis.** A sample with iAXIS=3 (AXIS_W=1 gives iAXIS=1 only; rerun with AXES=3, iAXIS=3) → oDROP pulses, no oUPD, and counters are unchanged.
6. **Reset mid-operation.**
   - Three samples of 500, then reset, then four samples of 64 → a single oUPD after the 4th post-reset sample, with amount 2, dir 0.
   - Reset asserted at the edge where stage 2 would fire → no oUPD.
